// File: rtl/paddle_pos_ctrl_pkg.sv
// Shared definitions for the paddle position scheduler: FSM encoding,
// table-half bounds and home positions derived from the screen geometry.
package paddle_pos_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SNAP   = 3'd1,
        ST_CLAMP1 = 3'd2,
        ST_STEP1  = 3'd3,
        ST_CLAMP2 = 3'd4,
        ST_STEP2  = 3'd5,
        ST_COMMIT = 3'd6
    } state_t;

    localparam int DEF_H_RES    = 800;
    localparam int DEF_V_RES    = 600;
    localparam int DEF_RADIUS   = 20;
    localparam int DEF_MAX_STEP = 16;

    // right = 1 selects player 2's half of the table
    function automatic int x_min(input int h_res, input int radius, input bit right);
        return right ? (h_res / 2 + radius) : radius;
    endfunction

    function automatic int x_max(input int h_res, input int radius, input bit right);
        return right ? (h_res - 1 - radius) : (h_res / 2 - 1 - radius);
    endfunction

    function automatic int y_max(input int v_res, input int radius);
        return v_res - 1 - radius;
    endfunction

    function automatic int home_x(input int h_res, input bit right);
        return right ? (3 * h_res / 4) : (h_res / 4);
    endfunction

    localparam int P1_XMIN   = x_min(DEF_H_RES, DEF_RADIUS, 1'b0);
    localparam int P1_XMAX   = x_max(DEF_H_RES, DEF_RADIUS, 1'b0);
    localparam int P2_XMIN   = x_min(DEF_H_RES, DEF_RADIUS, 1'b1);
    localparam int P2_XMAX   = x_max(DEF_H_RES, DEF_RADIUS, 1'b1);
    localparam int Y_MIN     = DEF_RADIUS;
    localparam int Y_MAX     = y_max(DEF_V_RES, DEF_RADIUS);
    localparam int P1_HOME_X = home_x(DEF_H_RES, 1'b0);
    localparam int P2_HOME_X = home_x(DEF_H_RES, 1'b1);
    localparam int HOME_Y    = DEF_V_RES / 2;

endpackage

// File: rtl/paddle_pos_ctrl_pos_step_limit.sv
// One axis of the paddle update: unsigned clamp into [lo, hi], then move the
// current position toward the clamped target by at most MAX_STEP.
module pos_step_limit #(
    parameter int DATA_W   = 12,
    parameter int MAX_STEP = 16
) (
    input  logic [DATA_W-1:0] target,
    input  logic [DATA_W-1:0] current,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] clamped,
    output logic [DATA_W-1:0] stepped
);

    localparam logic signed [DATA_W:0] STEP_MAX = (DATA_W + 1)'(MAX_STEP);
    localparam logic signed [DATA_W:0] STEP_MIN = -STEP_MAX;

    function automatic logic [DATA_W-1:0] clamp_u(input logic [DATA_W-1:0] v,
                                                  input logic [DATA_W-1:0] lo_v,
                                                  input logic [DATA_W-1:0] hi_v);
        if (v < lo_v) return lo_v;
        if (v > hi_v) return hi_v;
        return v;
    endfunction

    function automatic logic signed [DATA_W:0] sat_step(input logic signed [DATA_W:0] d);
        if (d > STEP_MAX) return STEP_MAX;
        if (d < STEP_MIN) return STEP_MIN;
        return d;
    endfunction

    logic signed [DATA_W:0] delta;
    logic signed [DATA_W:0] delta_sat;
    logic signed [DATA_W:0] sum;

    always_comb begin
        clamped   = clamp_u(target, lo, hi);
        delta     = $signed({1'b0, clamped}) - $signed({1'b0, current});
        delta_sat = sat_step(delta);
        // current and clamped target are both inside [lo, hi], so the sum is too
        sum       = $signed({1'b0, current}) + delta_sat;
        stepped   = sum[DATA_W-1:0];
    end

endmodule

// File: rtl/paddle_pos_ctrl.sv
// Per-frame paddle position scheduler: captures player requests, and on each
// vblank rising edge clamps, rate-limits and atomically commits both paddles.
module paddle_pos_ctrl
    import paddle_pos_ctrl_pkg::*;
#(
    parameter int H_RES    = DEF_H_RES,
    parameter int V_RES    = DEF_V_RES,
    parameter int RADIUS   = DEF_RADIUS,
    parameter int MAX_STEP = DEF_MAX_STEP,
    parameter int DATA_W   = 12
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              vblnk_in,
    input  logic              req_valid_p1,
    input  logic [DATA_W-1:0] xreq_p1,
    input  logic [DATA_W-1:0] yreq_p1,
    input  logic              req_valid_p2,
    input  logic [DATA_W-1:0] xreq_p2,
    input  logic [DATA_W-1:0] yreq_p2,
    output logic [DATA_W-1:0] xpos_out_player1,
    output logic [DATA_W-1:0] ypos_out_player1,
    output logic [DATA_W-1:0] xpos_out_player2,
    output logic [DATA_W-1:0] ypos_out_player2,
    output logic              busy,
    output logic              frame_tick,
    output logic              overrun
);

    localparam logic [DATA_W-1:0] P1_X_LO = DATA_W'(x_min(H_RES, RADIUS, 1'b0));
    localparam logic [DATA_W-1:0] P1_X_HI = DATA_W'(x_max(H_RES, RADIUS, 1'b0));
    localparam logic [DATA_W-1:0] P2_X_LO = DATA_W'(x_min(H_RES, RADIUS, 1'b1));
    localparam logic [DATA_W-1:0] P2_X_HI = DATA_W'(x_max(H_RES, RADIUS, 1'b1));
    localparam logic [DATA_W-1:0] Y_LO    = DATA_W'(RADIUS);
    localparam logic [DATA_W-1:0] Y_HI    = DATA_W'(y_max(V_RES, RADIUS));
    localparam logic [DATA_W-1:0] HOME_X1 = DATA_W'(home_x(H_RES, 1'b0));
    localparam logic [DATA_W-1:0] HOME_X2 = DATA_W'(home_x(H_RES, 1'b1));
    localparam logic [DATA_W-1:0] HOME_Y  = DATA_W'(V_RES / 2);

    state_t            state;
    logic              vblnk_q;
    logic              vblnk_rise;
    logic [DATA_W-1:0] pend_x1, pend_y1, pend_x2, pend_y2;
    logic [DATA_W-1:0] work_x1, work_y1, work_x2, work_y2;

    // Shared clamp/step datapath, time-multiplexed between the two players
    logic              sel_p2;
    logic [DATA_W-1:0] clamp_x, clamp_y, step_x, step_y;

    assign vblnk_rise = vblnk_in & ~vblnk_q;
    assign sel_p2     = (state == ST_CLAMP2) || (state == ST_STEP2);

    pos_step_limit #(.DATA_W(DATA_W), .MAX_STEP(MAX_STEP)) u_step_x (
        .target  (sel_p2 ? work_x2 : work_x1),
        .current (sel_p2 ? xpos_out_player2 : xpos_out_player1),
        .lo      (sel_p2 ? P2_X_LO : P1_X_LO),
        .hi      (sel_p2 ? P2_X_HI : P1_X_HI),
        .clamped (clamp_x),
        .stepped (step_x)
    );

    pos_step_limit #(.DATA_W(DATA_W), .MAX_STEP(MAX_STEP)) u_step_y (
        .target  (sel_p2 ? work_y2 : work_y1),
        .current (sel_p2 ? ypos_out_player2 : ypos_out_player1),
        .lo      (Y_LO),
        .hi      (Y_HI),
        .clamped (clamp_y),
        .stepped (step_y)
    );

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            vblnk_q          <= 1'b0;
            busy             <= 1'b0;
            frame_tick       <= 1'b0;
            overrun          <= 1'b0;
            pend_x1          <= HOME_X1;
            pend_y1          <= HOME_Y;
            pend_x2          <= HOME_X2;
            pend_y2          <= HOME_Y;
            work_x1          <= HOME_X1;
            work_y1          <= HOME_Y;
            work_x2          <= HOME_X2;
            work_y2          <= HOME_Y;
            xpos_out_player1 <= HOME_X1;
            ypos_out_player1 <= HOME_Y;
            xpos_out_player2 <= HOME_X2;
            ypos_out_player2 <= HOME_Y;
        end else begin
            vblnk_q    <= vblnk_in;
            frame_tick <= 1'b0;
            overrun    <= vblnk_rise && (state != ST_IDLE);

            if (req_valid_p1) begin
                pend_x1 <= xreq_p1;
                pend_y1 <= yreq_p1;
            end
            if (req_valid_p2) begin
                pend_x2 <= xreq_p2;
                pend_y2 <= yreq_p2;
            end

            case (state)
                ST_IDLE: begin
                    if (vblnk_rise) begin
                        state <= ST_SNAP;
                        busy  <= 1'b1;
                    end
                end
                // Snapshot takes pending values from before this cycle's requests
                ST_SNAP: begin
                    work_x1 <= pend_x1;
                    work_y1 <= pend_y1;
                    work_x2 <= pend_x2;
                    work_y2 <= pend_y2;
                    state   <= ST_CLAMP1;
                end
                ST_CLAMP1: begin
                    work_x1 <= clamp_x;
                    work_y1 <= clamp_y;
                    state   <= ST_STEP1;
                end
                ST_STEP1: begin
                    work_x1 <= step_x;
                    work_y1 <= step_y;
                    state   <= ST_CLAMP2;
                end
                ST_CLAMP2: begin
                    work_x2 <= clamp_x;
                    work_y2 <= clamp_y;
                    state   <= ST_STEP2;
                end
                ST_STEP2: begin
                    work_x2 <= step_x;
                    work_y2 <= step_y;
                    state   <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    xpos_out_player1 <= work_x1;
                    ypos_out_player1 <= work_y1;
                    xpos_out_player2 <= work_x2;
                    ypos_out_player2 <= work_y2;
                    frame_tick       <= 1'b1;
                    busy             <= 1'b0;
                    state            <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
